// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: default address/data widths, arbiter FSM state encoding and
// requester IDs used to tag the winner of an arbitration round.
package kgp_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Grant performance counters for the memory port arbiter.
// Built only when MEM_ARB_PERF_EN is defined.
// Ports: clk, rst (async active-low), if_gnt/d_gnt (one-cycle grant pulses),
//        perf_if_grants/perf_d_grants (16-bit wrapping grant counts).
module mem_arb_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_gnt,
  input  logic        d_gnt,
  output logic [15:0] perf_if_grants,
  output logic [15:0] perf_d_grants
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

  // Count one per grant pulse; natural wrap at 0xFFFF.
  always_comb begin
    if_cnt_d = if_cnt_q;
    d_cnt_d  = d_cnt_q;
    if (if_gnt) if_cnt_d = if_cnt_q + CNT_W'(1);
    if (d_gnt)  d_cnt_d  = d_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_cnt_q <= '0;
      d_cnt_q  <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      d_cnt_q  <= d_cnt_d;
    end
  end

  assign perf_if_grants = if_cnt_q;
  assign perf_d_grants  = d_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-port memory with fixed
// read latency LAT. One access in flight at a time: IDLE arbitrates,
// ACCESS drives the memory for one cycle, WAIT covers the latency, DONE
// returns the result. Data wins ties unless fetch has waited STARVE_MAX
// consecutive data grants.
// Ports: clk, rst (async active-low); fetch side if_req/if_addr/if_gnt/
//        if_valid/if_rdata; data side d_req/d_we/d_addr/d_wdata/d_gnt/
//        d_valid/d_rdata; memory side mem_en/mem_we/mem_addr/mem_wdata/
//        mem_rdata; perf_if_grants/perf_d_grants.
// Macro MEM_ARB_PERF_EN: enables grant counters (otherwise tied to 0).
module mem_port_arbiter
  import kgp_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       perf_if_grants,
  output logic [15:0]       perf_d_grants
);

  localparam int unsigned WCNT_W = 3;
  localparam int unsigned SCNT_W = 4;

  state_t              state_q, state_d;
  req_id_t             owner_q, owner_d;
  logic                we_q, we_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [SCNT_W-1:0]   starve_q, starve_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  // Next state and next registered outputs. Outputs are computed for the
  // state being entered so they are valid throughout that state's cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && (!if_req || (starve_q != SCNT_W'(STARVE_MAX)))) begin
          owner_d     = DATA;
          we_d        = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          mem_en_d    = 1'b1;
          d_gnt_d     = 1'b1;
          state_d     = ACCESS;
          // Winning while fetch waits implies starve_q < STARVE_MAX.
          if (if_req) starve_d = starve_q + SCNT_W'(1);
        end else if (if_req) begin
          owner_d    = FETCH;
          we_d       = 1'b0;
          mem_addr_d = if_addr;
          mem_en_d   = 1'b1;
          if_gnt_d   = 1'b1;
          starve_d   = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WCNT_W'(LAT - 1)) begin
          state_d = DONE;
          if (owner_q == DATA) begin
            d_valid_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= FETCH;
      we_q        <= 1'b0;
      wcnt_q      <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  // Counts follow the registered grant pulses, one cycle behind the grant.
  mem_arb_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .if_gnt         (if_gnt_q),
    .d_gnt          (d_gnt_q),
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants)
  );
`else
  assign perf_if_grants = 16'd0;
  assign perf_d_grants  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (LAT=2, STARVE_MAX=3).
module tb_mem_port_arbiter;
  import kgp_mem_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_valid, d_gnt, d_valid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   perf_if_grants, perf_d_grants;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory environment: read data appears LAT cycles after the access cycle;
  // other cycles carry random junk so a mistimed capture is visible.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:LAT-1];
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
    pipe[0] <= mem_en ? mem_model[mem_addr] : DW'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: one transaction at a time, next arbitration LAT+3
  // edges after a grant, tie-break by the starvation rule.
  typedef struct {
    req_id_t       who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t gq[$];
  exp_t cq[$];
  int   cyc = 0;
  int   busy = 0;
  int   starve = 0;
  int   m_perf_if = 0;
  int   m_perf_d = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d  = '0;

  always @(posedge clk or negedge rst) begin : model
    exp_t e;
    if (!rst) begin
      busy = 0; starve = 0; gq.delete(); cq.delete();
      last_if = '0; last_d = '0; m_perf_if = 0; m_perf_d = 0;
    end else begin
      cyc++;
      if (busy > 0) busy--;
      else if (if_req || d_req) begin
        if (d_req && (!if_req || starve != int'(SMAX))) begin
          e.who = DATA; e.we = d_we; e.addr = d_addr; e.wdata = d_wdata;
          if (if_req) starve = (starve < int'(SMAX)) ? starve + 1 : int'(SMAX);
          if (d_we) begin ref_mem[d_addr] = d_wdata; e.rdata = '0; end
          else e.rdata = ref_mem[d_addr];
          m_perf_d = (m_perf_d + 1) & 32'hFFFF;
        end else begin
          e.who = FETCH; e.we = 1'b0; e.addr = if_addr; e.wdata = '0;
          e.rdata = ref_mem[if_addr];
          starve = 0;
          m_perf_if = (m_perf_if + 1) & 32'hFFFF;
        end
        e.cyc = cyc;
        gq.push_back(e);
        e.cyc = cyc + int'(LAT) + 1;
        cq.push_back(e);
        busy = int'(LAT) + 2;
      end
    end
  end

  // Monitor: compares every grant and completion the DUT presents.
  logic log_en = 1'b0;
  int   glog[$];
  exp_t g, c;

  always @(negedge clk) begin
    if (rst) begin
      if (log_en && (if_gnt || d_gnt)) glog.push_back(d_gnt ? 1 : 0);
      if (if_gnt || d_gnt || mem_en) begin
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant if_gnt=%0b d_gnt=%0b mem_en=%0b required=none", if_gnt, d_gnt, mem_en);
        end else begin
          g = gq.pop_front();
          check("grant_cycle", 64'(cyc), 64'(g.cyc));
          check("if_gnt", 64'(if_gnt), 64'(g.who == FETCH));
          check("d_gnt", 64'(d_gnt), 64'(g.who == DATA));
          check("mem_en", 64'(mem_en), 64'(1));
          check("mem_we", 64'(mem_we), 64'(g.we));
          check("mem_addr", 64'(mem_addr), 64'(g.addr));
          if (g.we) check("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
        end
      end
      if (if_valid || d_valid) begin
        if (cq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid if_valid=%0b d_valid=%0b required=none", if_valid, d_valid);
        end else begin
          c = cq.pop_front();
          check("valid_cycle", 64'(cyc), 64'(c.cyc));
          check("if_valid", 64'(if_valid), 64'(c.who == FETCH));
          check("d_valid", 64'(d_valid), 64'(c.who == DATA));
          if (c.who == FETCH) begin
            check("if_rdata", 64'(if_rdata), 64'(c.rdata));
            last_if = c.rdata;
          end else if (!c.we) begin
            check("d_rdata", 64'(d_rdata), 64'(c.rdata));
            last_d = c.rdata;
          end else begin
            check("d_rdata_after_write", 64'(d_rdata), 64'(last_d));
          end
        end
      end else begin
        check("if_rdata_stable", 64'(if_rdata), 64'(last_if));
        check("d_rdata_stable", 64'(d_rdata), 64'(last_d));
      end
    end
  end

  task automatic do_fetch(input logic [AW-1:0] a, input bit hold);
    bit got = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL fetch_gnt_timeout actual=none required=if_gnt");
    end
    if (!hold) begin @(posedge clk); #1; if_req = 1'b0; end
  endtask

  task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
    bit got = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL data_gnt_timeout actual=none required=d_gnt");
    end
    if (!hold) begin @(posedge clk); #1; d_req = 1'b0; end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gq.size() == 0 && cq.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending_grants=%0d pending_valids=%0d required=0", gq.size(), cq.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_gnts"}, 64'({if_gnt, d_gnt}), 64'(0));
    check({tag, "_valids"}, 64'({if_valid, d_valid}), 64'(0));
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
    check({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
    check({tag, "_perf"}, 64'({perf_if_grants, perf_d_grants}), 64'(0));
  endtask

  task automatic check_perf(input string tag, input int exp_if, input int exp_d);
`ifdef MEM_ARB_PERF_EN
    check({tag, "_perf_if"}, 64'(perf_if_grants), 64'(exp_if));
    check({tag, "_perf_d"}, 64'(perf_d_grants), 64'(exp_d));
`else
    check({tag, "_perf_if"}, 64'(perf_if_grants), 64'(exp_if & 0));
    check({tag, "_perf_d"}, 64'(perf_d_grants), 64'(exp_d & 0));
`endif
  endtask

  int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_model[i] = $urandom;
      ref_mem[i]   = mem_model[i];
    end
    mem_model[4] = 32'hDEADBEEF;
    ref_mem[4]   = 32'hDEADBEEF;
    for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;

    repeat (3) @(posedge clk); #1;
    check_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Single fetch from a known location.
    do_fetch(10'h004, 0);
    drain();
    check("fetch_deadbeef", 64'(if_rdata), 64'(32'hDEADBEEF));

    // Data write to the top address; d_rdata must not move.
    do_data(1'b1, 10'h3FF, 32'h12345678, 0);
    drain();
    check("write_d_rdata_unchanged", 64'(d_rdata), 64'(0));
    check("write_landed", 64'(mem_model[10'h3FF]), 64'(32'h12345678));

    // Continuous contention: expect D,D,D,I,D,D,D,I.
    log_en = 1'b1;
    fork
      begin
        do_fetch(AW'($urandom_range(0, 15)), 1);
        do_fetch(AW'($urandom_range(0, 15)), 0);
      end
      begin
        for (int i = 0; i < 5; i++) do_data(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 1);
        do_data(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 0);
      end
    join
    drain();
    log_en = 1'b0;
    check("contention_count", 64'(glog.size()), 64'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++) check($sformatf("contention_order_%0d", i), 64'(glog[i]), 64'(pat[i]));

    // Random traffic from both sides.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        do_fetch(AW'($urandom_range(0, 15)), 0);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        do_data(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 0);
      end
    join
    drain();
    check_perf("random", m_perf_if, m_perf_d);

    // Reset while a fetch is in WAIT; fetch request stays pending.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 10'h008;
    begin
      bit got = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (if_gnt) begin got = 1; break; end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL midreset_gnt_timeout actual=none required=if_gnt");
      end
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero("mid_reset");
    if_addr = 10'h00C;
    repeat (3) @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_gnt_second_cycle", 64'(if_gnt), 64'(1));
    @(posedge clk); #1;
    if_req = 1'b0;
    drain();

    // Four more fetches and three data accesses after the reset.
    for (int i = 0; i < 4; i++) do_fetch(AW'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 3; i++) do_data(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 0);
    drain();
    check_perf("five_three", 5, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
